// File: rtl/text_write_sched_if.sv
// text_write_sched_if
// Bundles the two requester valid/ready/data channels and the text buffer
// write port of the OLED text write scheduler.
//   req0_valid/req0_data/req0_ready : requester 0 character channel
//   req1_valid/req1_data/req1_ready : requester 1 character channel
//   wr_en/wr_addr/wr_data           : registered text buffer write port
// Modports:
//   slave  : scheduler side (accepts characters, drives the write port)
//   master : requester/observer side
`timescale 1ns/1ps
interface text_write_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/text_write_sched.sv
// text_write_sched
// Write scheduler for the 4x16 character text buffer of the OLED text path.
// Round-robin arbitrates two character streams, keeps the cursor, interprets
// newline / backspace / form feed, and runs 64-cycle full-screen clear sweeps.
// Ports:
//   clk      : system clock, rising edge
//   rst_btn  : asynchronous active-low reset
//   bus      : requester handshakes + registered write port (slave modport)
//   clr_req  : clear-screen request, sampled every cycle while idle
//   cursor   : current cursor position {row[1:0], col[3:0]}
//   busy     : high while a clear sweep is running
`timescale 1ns/1ps
module text_write_sched #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst_btn,
    text_write_sched_if.slave         bus,
    input  logic                      clr_req,
    output logic [5:0]                cursor,
    output logic                      busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t     state;
    logic [5:0] sweepIdx;
    logic [5:0] cursorReg;
    logic       wrEnReg;
    logic [5:0] wrAddrReg;
    logic [7:0] wrDataReg;
    logic       lastGrant;   // 1: requester 1 was served last, so requester 0 wins a tie

    logic       grant0;
    logic       grant1;
    logic [7:0] charIn;
    logic [5:0] backCursor;
    logic [1:0] nextRow;
    logic       isPrintable;

    // Readys are combinational so a character is taken in the same cycle it
    // is offered; a clear request or running sweep blocks both channels.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !clr_req) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = lastGrant;
                grant1 = !lastGrant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        charIn      = grant1 ? bus.req1_data : bus.req0_data;
        backCursor  = (cursorReg == 6'd0) ? 6'd0 : cursorReg - 6'd1;
        nextRow     = cursorReg[5:4] + 2'd1;
        isPrintable = (charIn >= 8'h20) && (charIn <= 8'h7E);
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state     <= CLEAR;
            sweepIdx  <= 6'd0;
            cursorReg <= 6'd0;
            wrEnReg   <= 1'b0;
            wrAddrReg <= 6'd0;
            wrDataReg <= FILL_CHAR;
            lastGrant <= 1'b1;
        end else begin
            wrEnReg <= 1'b0;
            case (state)
                CLEAR: begin
                    // clr_req is deliberately not looked at here: a sweep in
                    // progress is neither restarted nor extended.
                    wrEnReg   <= 1'b1;
                    wrAddrReg <= sweepIdx;
                    wrDataReg <= FILL_CHAR;
                    sweepIdx  <= sweepIdx + 6'd1;
                    if (sweepIdx == 6'd63) begin
                        state     <= IDLE;
                        cursorReg <= 6'd0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        sweepIdx <= 6'd0;
                    end else if (grant0 || grant1) begin
                        lastGrant <= grant1;
                        if (isPrintable) begin
                            wrEnReg   <= 1'b1;
                            wrAddrReg <= cursorReg;
                            wrDataReg <= charIn;
                            cursorReg <= cursorReg + 6'd1;
                        end else if (charIn == 8'h0A) begin
                            cursorReg <= {nextRow, 4'd0};
                        end else if (charIn == 8'h08) begin
                            wrEnReg   <= 1'b1;
                            wrAddrReg <= backCursor;
                            wrDataReg <= FILL_CHAR;
                            cursorReg <= backCursor;
                        end else if (charIn == 8'h0C) begin
                            state    <= CLEAR;
                            sweepIdx <= 6'd0;
                        end
                        // any other code is consumed without effect
                    end
                end
                default: begin
                    state    <= CLEAR;
                    sweepIdx <= 6'd0;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.wr_en      = wrEnReg;
    assign bus.wr_addr    = wrAddrReg;
    assign bus.wr_data    = wrDataReg;
    assign cursor         = cursorReg;
    assign busy           = (state == CLEAR);

endmodule

// File: tb/tb_text_write_sched.sv
`timescale 1ns/1ps
module tb_text_write_sched;

    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic       clr_req = 1'b0;
    logic [5:0] cursor;
    logic       busy;

    int checks = 0;
    int errors = 0;

    text_write_sched_if tif();

    text_write_sched dut (
        .clk     (clk),
        .rst_btn (rst_btn),
        .bus     (tif),
        .clr_req (clr_req),
        .cursor  (cursor),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
        logic [5:0] cur;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        tif.req0_valid = v0;
        tif.req0_data  = d0;
        tif.req1_valid = v1;
        tif.req1_data  = d1;
    endtask

    // Expects 64 back-to-back fill writes at addresses 0..63, starting at the
    // next rising edge. Optionally pulses clr_req mid-sweep (must be ignored).
    task automatic sweep_check(input string name, input int clrAt);
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s_w%0d", name, k),
                  {wr_en_bit(), tif.wr_addr, tif.wr_data, busy},
                  {1'b1, 6'(k), 8'h20, (k < 63)});
            if (k < 63)
                check($sformatf("%s_rdy%0d", name, k), {tif.req0_ready, tif.req1_ready}, 2'b00);
            clr_req = (k == clrAt);
        end
        clr_req = 1'b0;
        check({name, "_cursor"}, cursor, 6'd0);
        $display("sweep %s done", name);
    endtask

    function automatic logic wr_en_bit();
        return tif.wr_en;
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 6'h00, 8'h48, 6'h01};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h69, 1'b0, 1'b1, 1'b1, 6'h01, 8'h69, 6'h02};
        vecs[2]  = '{1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 6'h02, 8'h41, 6'h03};
        vecs[3]  = '{1'b1, 8'h41, 1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 6'h03, 8'h42, 6'h04};
        vecs[4]  = '{1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 6'h04, 8'h41, 6'h05};
        vecs[5]  = '{1'b1, 8'h41, 1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 6'h05, 8'h42, 6'h06};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'h05, 8'h42, 6'h06};
        vecs[7]  = '{1'b1, 8'h0A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'h05, 8'h42, 6'h10};
        vecs[8]  = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 6'h0F, 8'h20, 6'h0F};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 6'h0F, 8'h20, 6'h0F};
        vecs[10] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 6'h0F, 8'h5A, 6'h10};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h31, 1'b0, 1'b1, 1'b1, 6'h10, 8'h31, 6'h11};
        vecs[12] = '{1'b1, 8'h32, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 6'h11, 8'h32, 6'h12};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 6'h12, 8'h33, 6'h13};
        vecs[14] = '{1'b1, 8'h0A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'h12, 8'h33, 6'h20};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 6'h12, 8'h33, 6'h20};

        set_inputs(1'b0, 8'h00, 1'b0, 8'h00);

        // Reset state while held in reset
        #22;
        check("reset_vals", {tif.wr_en, tif.wr_addr, tif.wr_data, cursor, busy, tif.req0_ready, tif.req1_ready},
              {1'b0, 6'd0, 8'h20, 6'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst_btn = 1'b1;
        sweep_check("init", -1);

        // No 65th write after the sweep
        @(posedge clk); #1;
        check("post_sweep_idle", {tif.wr_en, busy, cursor}, {1'b0, 1'b0, 6'd0});

        // Table-driven vectors, starting at cursor 0 with req0 favoured
        for (int i = 0; i < 16; i++) begin
            set_inputs(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {tif.req0_ready, tif.req1_ready}, {vecs[i].r0, vecs[i].r1});
            @(posedge clk); #1;
            check($sformatf("vec%0d_write", i), {tif.wr_en, tif.wr_addr, tif.wr_data},
                  {vecs[i].we, vecs[i].addr, vecs[i].data});
            check($sformatf("vec%0d_cursor", i), cursor, vecs[i].cur);
            $display("vec %0d: v0=%0b d0=%h v1=%0b d1=%h -> we=%0b addr=%h data=%h cursor=%h",
                     i, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1,
                     tif.wr_en, tif.wr_addr, tif.wr_data, cursor);
        end

        // Form feed: accepted, no character write, sweep follows
        set_inputs(1'b1, 8'h0C, 1'b0, 8'h00);
        @(negedge clk);
        check("ff_ready", {tif.req0_ready, tif.req1_ready}, 2'b10);
        @(posedge clk); #1;
        check("ff_enter", {tif.wr_en, busy}, {1'b0, 1'b1});
        set_inputs(1'b0, 8'h00, 1'b0, 8'h00);
        sweep_check("ff", -1);

        // Backspace at cursor 0
        set_inputs(1'b1, 8'h08, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("bs_zero", {tif.wr_en, tif.wr_addr, tif.wr_data, cursor}, {1'b1, 6'd0, 8'h20, 6'd0});
        $display("backspace at 0: addr=%h cursor=%h", tif.wr_addr, cursor);

        // Cursor wrap: 64 printable characters
        set_inputs(1'b1, 8'h41, 1'b0, 8'h00);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            check($sformatf("wrap_rdy%0d", k), tif.req0_ready, 1'b1);
            @(posedge clk); #1;
            check($sformatf("wrap_w%0d", k), {tif.wr_en, tif.wr_addr, tif.wr_data}, {1'b1, 6'(k), 8'h41});
        end
        check("wrap_cursor", cursor, 6'd0);
        set_inputs(1'b1, 8'h42, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("wrap_next", {tif.wr_en, tif.wr_addr, tif.wr_data, cursor}, {1'b1, 6'd0, 8'h42, 6'd1});
        $display("wrap: next char at addr=%h cursor=%h", tif.wr_addr, cursor);

        // clr_req beats a simultaneous valid; req0 waits out the sweep
        set_inputs(1'b1, 8'h43, 1'b0, 8'h00);
        clr_req = 1'b1;
        @(negedge clk);
        check("clr_vs_valid_rdy", {tif.req0_ready, tif.req1_ready}, 2'b00);
        @(posedge clk); #1;
        check("clr_enter", {tif.wr_en, busy}, {1'b0, 1'b1});
        clr_req = 1'b0;
        sweep_check("clr", 10);
        @(negedge clk);
        check("clr_after_rdy", tif.req0_ready, 1'b1);
        @(posedge clk); #1;
        check("clr_after_w", {tif.wr_en, tif.wr_addr, tif.wr_data, cursor}, {1'b1, 6'd0, 8'h43, 6'd1});
        set_inputs(1'b0, 8'h00, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a sweep
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_sweep_addr", {tif.wr_en, tif.wr_addr}, {1'b1, 6'd29});
        #2;
        rst_btn = 1'b0;
        #1;
        check("async_reset_vals", {tif.wr_en, tif.wr_addr, tif.wr_data, cursor, busy},
              {1'b0, 6'd0, 8'h20, 6'd0, 1'b1});
        @(negedge clk);
        rst_btn = 1'b1;
        sweep_check("rst", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
